// File: rtl/rd_fwft_if.sv
// Handshake bundle between the read-domain FWFT output stage, the read-pointer
// block / memory read port on one side, and the stream consumer on the other.
interface rd_fwft_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rempty;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           stall_cnt;

  modport slave (
    input  rempty, rdata, out_ready,
    output read_enable, out_data, out_valid, stall_cnt
  );

  modport master (
    output rempty, rdata, out_ready,
    input  read_enable, out_data, out_valid, stall_cnt
  );
endinterface

// File: rtl/rd_fwft_stage.sv
// Read-domain FWFT output stage: 3-entry prefetch buffer turning read_enable/rempty
// plus 1-cycle memory latency into a valid/ready stream. Stall counter under RD_FWFT_STATS_EN.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | no buffered word, out_valid low
// ST_ONE   | one buffered word (steady streaming state)
// ST_TWO   | two buffered words
// ST_FULL  | three buffered words, no read may be in flight
module rd_fwft_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       rclk,
  input  logic       rrst_n,
  rd_fwft_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2,
    ST_FULL  = 2'd3
  } occ_e;

  occ_e                  state_q, state_d;
  logic                  inflight_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [DATA_WIDTH-1:0] buf_d [3];
  logic                  accept;
  logic                  pop;
  logic                  land;
  logic [1:0]            wr_idx;
  logic [2:0]            committed;

  // Reads are gated only by registered state so out_ready never reaches read_enable.
  assign committed       = {1'b0, state_q} + {2'b00, inflight_q};
  assign bus.read_enable = rrst_n && !bus.rempty && (committed < 3'd3);
  assign accept          = bus.read_enable;
  assign pop             = out_valid_q && bus.out_ready;
  assign land            = inflight_q;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = buf_q[0];

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    wr_idx  = state_q - {1'b0, pop};
    case ({land, pop})
      2'b10:   state_d = occ_e'(state_q + 2'd1);
      2'b01:   state_d = occ_e'(state_q - 2'd1);
      default: state_d = state_q;
    endcase
    if (pop) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
    end
    // Landing word goes behind whatever survives the pop, preserving order.
    if (land && (wr_idx != 2'd3)) begin
      buf_d[wr_idx] = bus.rdata;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= ST_EMPTY;
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      buf_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      inflight_q  <= accept;
      out_valid_q <= (state_d != ST_EMPTY);
      buf_q       <= buf_d;
    end
  end

`ifdef RD_FWFT_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (out_valid_q && !bus.out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'd0;
`endif

  // A full buffer can never have a word in flight.
  assert property (@(posedge rclk) disable iff (!rrst_n) !(inflight_q && (state_q == ST_FULL)))
    else $error("rd_fwft_stage: landing into full buffer");

endmodule

// File: tb/tb_rd_fwft_stage.sv
// Bench for rd_fwft_stage: directed phases plus a random phase, checked against a
// queue-based model of the upstream FIFO, the prefetch buffer and the consumer.
module tb_rd_fwft_stage;

  logic rclk   = 1'b0;
  logic rrst_n = 1'b0;

  always #5 rclk = ~rclk;

  rd_fwft_if #(.DATA_WIDTH(8)) bus ();

  rd_fwft_stage #(.DATA_WIDTH(8)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  int         m_stall = 0;
  bit         m_inf  = 1'b0;
  bit         hold_empty = 1'b1;
  logic [7:0] land_word = 8'h00;
  logic [7:0] src_q [$];
  logic [7:0] m_buf [$];
  logic [7:0] pop_data_q [$];
  int         pop_cyc_q [$];
  int         start;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    bus.rempty = hold_empty || (src_q.size() == 0);
    bus.rdata  = m_inf ? land_word : 8'($urandom);
  endtask

  // One rclk cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit exp_re;
    bit exp_v;
    bit acc;
    bit pop;
    @(negedge rclk);
    exp_re = !bus.rempty && ((m_buf.size() + int'(m_inf)) < 3);
    exp_v  = (m_buf.size() != 0);
    chk("read_enable", 16'(bus.read_enable), 16'(exp_re));
    chk("out_valid", 16'(bus.out_valid), 16'(exp_v));
    if (exp_v) chk("out_data", 16'(bus.out_data), 16'(m_buf[0]));
`ifdef RD_FWFT_STATS_EN
    chk("stall_cnt", bus.stall_cnt, 16'(m_stall));
`else
    chk("stall_cnt", bus.stall_cnt, 16'd0);
`endif
    acc = exp_re;
    pop = exp_v && bus.out_ready;
    if (pop) begin
      pop_data_q.push_back(bus.out_data);
      pop_cyc_q.push_back(cyc);
    end
    @(posedge rclk);
    if (exp_v && !bus.out_ready && (m_stall < 65535)) m_stall++;
    if (pop) void'(m_buf.pop_front());
    if (m_inf) m_buf.push_back(land_word);
    m_inf = acc;
    if (acc) land_word = src_q.pop_front();
    cyc++;
    #1;
    drive_inputs();
  endtask

  task automatic do_reset();
    #2 rrst_n = 1'b0;
    #1;
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_stall_cnt", bus.stall_cnt, 16'd0);
    chk("rst_read_enable", 16'(bus.read_enable), 16'd0);
    src_q.delete();
    m_buf.delete();
    m_inf      = 1'b0;
    m_stall    = 0;
    hold_empty = 1'b1;
    drive_inputs();
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    @(posedge rclk);
    #1;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    drive_inputs();
    #1;
    chk("por_out_valid", 16'(bus.out_valid), 16'd0);
    chk("por_out_data", 16'(bus.out_data), 16'd0);
    chk("por_read_enable", 16'(bus.read_enable), 16'd0);
    chk("por_stall_cnt", bus.stall_cnt, 16'd0);
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    @(posedge rclk);
    #1;

    // Idle with rempty held high
    repeat (10) begin
      tick();
      chk("idle_out_data", 16'(bus.out_data), 16'd0);
    end

    // Single word, held under backpressure, then popped
    src_q.push_back(8'hA5);
    hold_empty = 1'b0;
    drive_inputs();
    repeat (7) tick();
    chk("single_hold_valid", 16'(bus.out_valid), 16'd1);
    chk("single_hold_data", 16'(bus.out_data), 16'h00A5);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    chk("single_after_pop_valid", 16'(bus.out_valid), 16'd0);

    // Streaming 01..10 with constant ready
    pop_data_q.delete();
    pop_cyc_q.delete();
    for (int i = 1; i <= 16; i++) src_q.push_back(8'(i));
    bus.out_ready = 1'b1;
    drive_inputs();
    start = cyc;
    repeat (20) tick();
    chk("stream_beats", 16'(pop_data_q.size()), 16'd16);
    for (int i = 0; i < pop_data_q.size(); i++) begin
      chk("stream_order", 16'(pop_data_q[i]), 16'(i + 1));
      chk("stream_cycle", 16'(pop_cyc_q[i] - start), 16'(i + 2));
    end

    // Backpressure from the second beat
    pop_data_q.delete();
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    bus.out_ready = 1'b1;
    drive_inputs();
    repeat (8) begin
      tick();
      if (pop_data_q.size() >= 1) bus.out_ready = 1'b0;
    end
    chk("bp_read_enable", 16'(bus.read_enable), 16'd0);
    chk("bp_out_valid", 16'(bus.out_valid), 16'd1);
    chk("bp_head", 16'(bus.out_data), 16'h0002);
    bus.out_ready = 1'b1;
    repeat (12) tick();
    chk("bp_beats", 16'(pop_data_q.size()), 16'd8);
    for (int i = 0; i < pop_data_q.size(); i++) chk("bp_order", 16'(pop_data_q[i]), 16'(i + 1));

    // Land and pop together with one word buffered
    bus.out_ready = 1'b0;
    src_q.push_back(8'h31);
    src_q.push_back(8'h32);
    drive_inputs();
    tick();
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("lp_valid", 16'(bus.out_valid), 16'd1);
    chk("lp_head", 16'(bus.out_data), 16'h0032);
    tick();
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("lp_single_left", 16'(bus.out_valid), 16'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (($urandom_range(0, 2) != 0) && (src_q.size() < 20)) src_q.push_back(8'($urandom));
      hold_empty    = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      drive_inputs();
      tick();
    end
    hold_empty    = 1'b0;
    bus.out_ready = 1'b1;
    drive_inputs();
    repeat (40) tick();
    chk("rand_drained", 16'(bus.out_valid), 16'd0);

    // Stall counting then reset mid-stream
    do_reset();
    bus.out_ready = 1'b0;
    src_q.push_back(8'h71);
    src_q.push_back(8'h72);
    src_q.push_back(8'h73);
    src_q.push_back(8'h74);
    hold_empty = 1'b0;
    drive_inputs();
    for (int i = 0; (i < 20) && (m_stall < 7); i++) tick();
`ifdef RD_FWFT_STATS_EN
    chk("stall_seven", bus.stall_cnt, 16'd7);
`else
    chk("stall_tied_zero", bus.stall_cnt, 16'd0);
`endif
    do_reset();
    repeat (3) tick();
    src_q.push_back(8'h5A);
    hold_empty = 1'b0;
    drive_inputs();
    repeat (4) tick();
    chk("post_rst_valid", 16'(bus.out_valid), 16'd1);
    chk("post_rst_head", 16'(bus.out_data), 16'h005A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rd_fwft_stage.md
Name: rd_fwft_stage

Overview:
- Read-domain output stage of the async FIFO. Sits directly downstream of the read-pointer block and the dual-port memory read port.
- Converts the pointer block's read_enable/rempty interface and the 1-cycle-latency memory read data into a first-word-fall-through valid/ready stream for the consumer.
- Contains a 3-entry prefetch buffer, so it sustains one word per rclk with no combinational path from out_ready to read_enable.

Parameters:
- DATA_WIDTH, 8, width of the memory word and of the stream data.

Ports:
- rclk  input  1  read-domain clock.
- rrst_n  input  1  asynchronous active-low reset, read domain.
- rempty  input  1  registered empty flag from the read-pointer block.
- read_enable  output  1  read request to the read-pointer block; also the memory read strobe.
- rdata  input  DATA_WIDTH  memory read data; valid the cycle after an accepted read.
- out_data  output  DATA_WIDTH  stream data, head of the prefetch buffer.
- out_valid  output  1  stream valid.
- out_ready  input  1  consumer ready.
- stall_cnt  output  16  stall-cycle counter (only with RD_FWFT_STATS_EN).

Behaviour:
- Clock and reset: one clock, rclk. Reset rrst_n is asynchronous, active-low.
- Reset values:
  - buffer occupancy = 0, inflight = 0, all buffer entries = 0.
  - out_valid = 0, out_data = 0, stall_cnt = 0.
  - read_enable is low during reset because rempty resets to 1 upstream. It is additionally forced low while rrst_n = 0.
- Accepted read: read_enable && !rempty in cycle N. inflight is registered = 1 at the end of cycle N.
- read_enable = !rempty && (occ + inflight < 3). Combinational from registered state only, never from out_ready.
- Landing: when inflight = 1, rdata is written into the buffer at the end of that cycle (cycle N+1). inflight clears unless a new read is accepted in the same cycle.
- Pop: out_valid && out_ready pops the head at the clock edge.
- Occupancy states: EMPTY(0), ONE(1), TWO(2), FULL(3). Transitions at each edge, with next occ = occ + land - pop:
  - land only: +1
  - pop only: -1
  - land and pop together: unchanged; the new word is queued behind the remaining entries and data order is strictly preserved.
- out_valid = (occ != 0), registered state. out_data = head entry, and is stable while out_valid && !out_ready.
- Latency: with occ = 0, inflight = 0 and rempty falling in cycle N:
  - read_enable is high in cycle N.
  - out_valid goes high in cycle N+2.
- Throughput: with a continuous out_ready and a non-empty FIFO, steady state is occ = 1 and inflight = 1, giving one word per cycle.
- Overflow guard: occ + inflight never exceeds 3. A landing with occ = 3 is impossible by construction; an assertion flags it.
- rempty rising mid-stream: no new reads are issued. Inflight data still lands and buffered words drain normally.
- Reset mid-operation: buffered and inflight words are discarded and out_valid drops immediately (asynchronously). After release, no read is issued until rempty = 0.

Optional Feature:
- Macro: RD_FWFT_STATS_EN.
- Defined:
  - stall_cnt increments by 1 on each cycle with out_valid && !out_ready.
  - It saturates at 16'hFFFF and resets to 0.
- Undefined:
  - The stall_cnt port is still present and tied to 0.
  - No counter logic is synthesized.

Test Plan:
- Reset then idle: hold rempty = 1 for 10 cycles -> read_enable = 0, out_valid = 0, out_data = 0 throughout.
- Single word: rempty low for one cycle at N, rdata = 8'hA5 in N+1, out_ready = 0 -> out_valid = 1 from N+2 with out_data = 8'hA5, held stable for 5 cycles. Then out_ready = 1 for one cycle -> out_valid = 0 the next cycle.
- Streaming: FIFO holds 8'h01..8'h10 (16 words), out_ready = 1 constantly -> 16 consecutive beats in order 01..10 with no gaps after the first, total 18 cycles.
- Backpressure: stream 8'h01..8'h08, out_ready = 0 from the 2nd beat -> read_enable drops once occ + inflight = 3. Releasing out_ready yields 02..08 in order with no loss or duplication.
- Simultaneous land and pop at occ = 1: verify occ stays 1 and the order is preserved (head popped, landed word becomes the next head).
- Reset mid-stream, plus stats: with RD_FWFT_STATS_EN defined, stall for 7 cycles -> stall_cnt = 7. Assert rrst_n = 0 -> stall_cnt = 0 and out_valid = 0 immediately, and no stale word appears after release.
